// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Good words are presented on a valid/ready output; dropped frames raise one-cycle error pulses.
module serial_frame_rx #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              si,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PAR, STOP} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_shadow;
  logic                r_par;
  logic [DATA_W-1:0]   r_data;
  logic                r_valid;
  logic                r_perr;
  logic                r_ferr;
  logic                r_ovr;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_W-1:0]   w_shadow_nxt;
  logic                w_par_nxt;
  logic [DATA_W-1:0]   w_data_nxt;
  logic                w_valid_nxt;
  logic                w_perr_nxt;
  logic                w_ferr_nxt;
  logic                w_ovr_nxt;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
      r_par    <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovr    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_shadow <= w_shadow_nxt;
      r_par    <= w_par_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_perr   <= w_perr_nxt;
      r_ferr   <= w_ferr_nxt;
      r_ovr    <= w_ovr_nxt;
    end
  end

  // Next-state, deserialiser and frame resolution
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shadow_nxt = r_shadow;
    w_par_nxt    = r_par;
    w_data_nxt   = r_data;
    w_valid_nxt  = r_valid & ~out_ready;
    w_perr_nxt   = 1'b0;
    w_ferr_nxt   = 1'b0;
    w_ovr_nxt    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (!si) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = '0;
          w_par_nxt   = 1'b0;
        end
      end
      DATA: begin
        // Shifting in from the MSB end leaves the first bit at the LSB after DATA_W bits
        w_shadow_nxt = {si, r_shadow[DATA_W-1:1]};
        w_par_nxt    = r_par ^ si;
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_W'(DATA_W - 1)) begin
          w_state_nxt = PARITY_EN ? PAR : STOP;
        end
      end
      PAR: begin
        w_par_nxt   = r_par ^ si;
        w_state_nxt = STOP;
      end
      STOP: begin
        w_state_nxt = IDLE;
        if (!si) begin
          w_ferr_nxt = 1'b1;
        end else if (PARITY_EN && r_par) begin
          w_perr_nxt = 1'b1;
        end else if (r_valid && !out_ready) begin
          w_ovr_nxt = 1'b1;
        end else begin
          w_data_nxt  = r_shadow;
          w_valid_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign out_data   = r_data;
  assign out_valid  = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: directed frames plus random frames against a frame-level model.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       si;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;

  logic       si2;
  logic       ready2;
  logic [7:0] out_data2;
  logic       out_valid2;
  logic       parity_err2;
  logic       frame_err2;
  logic       overrun2;

  int total = 0;
  int bad   = 0;

  // Frame-level reference: the word currently held and whether it is unconsumed
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] m_pending;

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .si(si),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun)
  );

  serial_frame_rx #(.DATA_W(8), .PARITY_EN(1'b0)) u_dut_np (
    .clk(clk), .rst(rst), .si(si2),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(ready2),
    .parity_err(parity_err2), .frame_err(frame_err2), .overrun(overrun2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit time: drive, clock, update the model, then compare every output
  task automatic tick(input logic s, input logic rdy, input bit is_stop, input bit par_bad);
    logic e_perr, e_ferr, e_ovr, full, load;
    si = s;
    out_ready = rdy;
    @(posedge clk);
    e_perr = 1'b0; e_ferr = 1'b0; e_ovr = 1'b0; load = 1'b0;
    full = m_valid && !rdy;
    if (is_stop) begin
      if (!s)           e_ferr = 1'b1;
      else if (par_bad) e_perr = 1'b1;
      else if (full)    e_ovr  = 1'b1;
      else begin
        m_data = m_pending;
        load   = 1'b1;
      end
    end
    m_valid = full || load;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("parity_err", 32'(parity_err), 32'(e_perr));
    chk("frame_err", 32'(frame_err), 32'(e_ferr));
    chk("overrun", 32'(overrun), 32'(e_ovr));
    if (m_valid) chk("out_data", 32'(out_data), 32'(m_data));
  endtask

  // rmode 0: ready low except rstop at the stop bit; 1: ready high; 2: random
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int rmode, input logic rstop);
    logic pbit;
    logic r;
    pbit = (^d) ^ bad_par;
    m_pending = d;
    for (int i = 0; i < 11; i++) begin
      case (rmode)
        0:       r = (i == 10) ? rstop : 1'b0;
        1:       r = 1'b1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (i == 0)       tick(1'b0, r, 1'b0, 1'b0);
      else if (i <= 8)  tick(d[i-1], r, 1'b0, 1'b0);
      else if (i == 9)  tick(pbit, r, 1'b0, 1'b0);
      else              tick(~bad_stop, r, 1'b1, bad_par);
    end
  endtask

  task automatic idle(input int n, input int rmode);
    for (int i = 0; i < n; i++)
      tick(1'b1, (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode), 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic [9:0] f2;
    rst = 1'b1; si = 1'b1; out_ready = 1'b0; si2 = 1'b1; ready2 = 1'b0;
    m_valid = 1'b0; m_data = '0; m_pending = '0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_errs", 32'({parity_err, frame_err, overrun}), 32'd0);
    @(negedge clk); rst = 1'b0;
    idle(3, 0);

    // Good frame held, then consumed
    send_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0);
    idle(4, 0);
    idle(1, 1);
    idle(2, 0);

    // Parity error, framing error then immediate good frame
    send_frame(8'hA5, 1'b1, 1'b0, 0, 1'b0);
    idle(2, 0);
    send_frame(8'h3C, 1'b0, 1'b1, 0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 1);

    // Overrun back-to-back, then transfer-and-load in the same cycle
    send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 1);
    send_frame(8'h11, 1'b0, 1'b0, 0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 0, 1'b1);
    idle(2, 1);

    // Reset mid-frame after 4 data bits of 0xFF, with a word still held
    send_frame(8'h77, 1'b0, 1'b0, 0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1; si = 1'b1;
    #2;
    m_valid = 1'b0; m_data = '0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_errs", 32'({parity_err, frame_err, overrun}), 32'd0);
    @(negedge clk); rst = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 1);

    // Random frames, errors and back-pressure
    for (int n = 0; n < 60; n++) begin
      d = 8'($urandom);
      send_frame(d, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), 2, 1'b0);
      idle($urandom_range(0, 2), 2);
    end

    // Idle line
    idle(50, 2);

    // No-parity variant: 10-bit frame 0x80
    f2 = {1'b1, 8'h80, 1'b0};
    for (int i = 0; i < 10; i++) begin
      si2 = f2[i];
      @(posedge clk); #1;
      chk("np_valid", 32'(out_valid2), (i == 9) ? 32'd1 : 32'd0);
    end
    si2 = 1'b1;
    chk("np_data", 32'(out_data2), 32'h80);
    chk("np_errs", 32'({parity_err2, frame_err2, overrun2}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
